// File: rtl/pcie_prp_rd_sched.sv
// PRP-list read scheduler: splits a host fetch into 4KB-safe PCIe memory reads,
// throttled by completion-tag availability and receive-FIFO free space.
module pcie_prp_rd_sched #(
  parameter int C_PCIE_ADDR_WIDTH  = 36,
  parameter int P_FIFO_DEPTH_WIDTH = 5,
  parameter int C_LEN_WIDTH        = 7,
  parameter int C_MAX_RD_UNITS     = 2
) (
  input  logic                          pcie_user_clk,
  input  logic                          pcie_user_rst,
  input  logic                          prp_rd_req,
  output logic                          prp_rd_req_ready,
  input  logic [C_PCIE_ADDR_WIDTH-7:0]  prp_rd_addr,
  input  logic [C_LEN_WIDTH-1:0]        prp_rd_len,
  output logic                          prp_rd_done,
  output logic                          tx_mrd_req,
  input  logic                          tx_mrd_req_ack,
  output logic [C_PCIE_ADDR_WIDTH-3:0]  tx_mrd_addr,
  output logic [9:0]                    tx_mrd_len,
  output logic [7:0]                    tx_mrd_tag,
  output logic                          pcie_tag_alloc,
  output logic [7:0]                    pcie_alloc_tag,
  output logic [1:0]                    pcie_tag_alloc_len,
  input  logic                          pcie_tag_full_n,
  input  logic [P_FIFO_DEPTH_WIDTH:0]   rear_full_addr,
  input  logic [P_FIFO_DEPTH_WIDTH:0]   fifo_front_addr
);

  typedef enum logic [2:0] {S_IDLE, S_CALC, S_CHECK, S_REQ, S_UPDATE} state_t;

  localparam logic [P_FIFO_DEPTH_WIDTH:0] LP_DEPTH = (P_FIFO_DEPTH_WIDTH+1)'(2**P_FIFO_DEPTH_WIDTH);

  state_t                         r_state;
  state_t                         w_next;
  logic [C_PCIE_ADDR_WIDTH-7:0]   r_cur_addr;
  logic [C_LEN_WIDTH-1:0]         r_remain;
  logic [1:0]                     r_chunk;
  logic [2:0]                     r_tag_cnt;
  logic                           r_done;
  logic                           r_req;
  logic [C_PCIE_ADDR_WIDTH-3:0]   r_tx_addr;
  logic [9:0]                     r_tx_len;
  logic [7:0]                     r_tx_tag;

  logic [P_FIFO_DEPTH_WIDTH:0]    w_used;
  logic [P_FIFO_DEPTH_WIDTH:0]    w_free;
  logic [C_LEN_WIDTH-1:0]         w_room;
  logic [C_LEN_WIDTH-1:0]         w_new_remain;
  logic [1:0]                     w_chunk;
  logic                           w_can_issue;
  logic                           w_ack;

  // Pointer difference wraps naturally thanks to the extra wrap bit.
  assign w_used       = rear_full_addr - fifo_front_addr;
  assign w_free       = LP_DEPTH - w_used;
  assign w_room       = C_LEN_WIDTH'(64) - C_LEN_WIDTH'(r_cur_addr[5:0]);
  assign w_new_remain = r_remain - C_LEN_WIDTH'(r_chunk);
  assign w_can_issue  = pcie_tag_full_n && (w_free >= (P_FIFO_DEPTH_WIDTH+1)'(r_chunk));
  assign w_ack        = r_req & tx_mrd_req_ack;

  always_comb begin
    w_chunk = 2'(C_MAX_RD_UNITS);
    if (r_remain < C_LEN_WIDTH'(w_chunk)) w_chunk = r_remain[1:0];
    if (w_room < C_LEN_WIDTH'(w_chunk))   w_chunk = w_room[1:0];
  end

  always_ff @(posedge pcie_user_clk or posedge pcie_user_rst) begin
    if (pcie_user_rst) r_state <= S_IDLE;
    else               r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   if (prp_rd_req && prp_rd_len != '0) w_next = S_CALC;
      S_CALC:   w_next = S_CHECK;
      S_CHECK:  if (w_can_issue) w_next = S_REQ;
      S_REQ:    if (w_ack) w_next = S_UPDATE;
      S_UPDATE: w_next = (w_new_remain == '0) ? S_IDLE : S_CALC;
      default:  w_next = S_IDLE;
    endcase
  end

  always_comb begin
    prp_rd_req_ready   = (r_state == S_IDLE);
    prp_rd_done        = r_done;
    tx_mrd_req         = r_req;
    tx_mrd_addr        = r_tx_addr;
    tx_mrd_len         = r_tx_len;
    tx_mrd_tag         = r_tx_tag;
    pcie_tag_alloc     = w_ack;
    pcie_alloc_tag     = r_tx_tag;
    pcie_tag_alloc_len = r_chunk;
  end

  always_ff @(posedge pcie_user_clk or posedge pcie_user_rst) begin
    if (pcie_user_rst) begin
      r_cur_addr <= '0;
      r_remain   <= '0;
      r_chunk    <= '0;
      r_tag_cnt  <= '0;
      r_done     <= 1'b0;
      r_req      <= 1'b0;
      r_tx_addr  <= '0;
      r_tx_len   <= '0;
      r_tx_tag   <= 8'h08;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (prp_rd_req) begin
            r_cur_addr <= prp_rd_addr;
            r_remain   <= prp_rd_len;
            r_done     <= (prp_rd_len == '0);
          end
        end
        S_CALC: r_chunk <= w_chunk;
        S_CHECK: begin
          if (w_can_issue) begin
            r_tx_addr <= {r_cur_addr, 4'b0000};
            r_tx_len  <= {4'b0000, r_chunk, 4'b0000};
            r_tx_tag  <= {5'b00001, r_tag_cnt};
            r_req     <= 1'b1;
          end
        end
        S_REQ: begin
          if (w_ack) begin
            r_req     <= 1'b0;
            r_tag_cnt <= r_tag_cnt + 3'd1;
          end
        end
        S_UPDATE: begin
          r_cur_addr <= r_cur_addr + (C_PCIE_ADDR_WIDTH-6)'(r_chunk);
          r_remain   <= w_new_remain;
          r_done     <= (w_new_remain == '0);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_pcie_prp_rd_sched.sv
// Directed bench for pcie_prp_rd_sched: expected MRd transactions are queued
// when a fetch is issued and compared as the TX side accepts them.
module tb_pcie_prp_rd_sched;

  logic        clk;
  logic        rst;
  logic        prpRdReq;
  logic        prpRdReqReady;
  logic [29:0] prpRdAddr;
  logic [6:0]  prpRdLen;
  logic        prpRdDone;
  logic        txMrdReq;
  logic        txMrdReqAck;
  logic [33:0] txMrdAddr;
  logic [9:0]  txMrdLen;
  logic [7:0]  txMrdTag;
  logic        tagAlloc;
  logic [7:0]  allocTag;
  logic [1:0]  allocLen;
  logic        tagFullN;
  logic [5:0]  rearFullAddr;
  logic [5:0]  fifoFrontAddr;

  typedef struct packed {
    logic [33:0] addr;
    logic [9:0]  len;
    logic [7:0]  tag;
  } mrd_t;

  mrd_t        expQ[$];
  logic [2:0]  expTag;
  int          checks = 0;
  int          failures = 0;

  pcie_prp_rd_sched dut (
    .pcie_user_clk      (clk),
    .pcie_user_rst      (rst),
    .prp_rd_req         (prpRdReq),
    .prp_rd_req_ready   (prpRdReqReady),
    .prp_rd_addr        (prpRdAddr),
    .prp_rd_len         (prpRdLen),
    .prp_rd_done        (prpRdDone),
    .tx_mrd_req         (txMrdReq),
    .tx_mrd_req_ack     (txMrdReqAck),
    .tx_mrd_addr        (txMrdAddr),
    .tx_mrd_len         (txMrdLen),
    .tx_mrd_tag         (txMrdTag),
    .pcie_tag_alloc     (tagAlloc),
    .pcie_alloc_tag     (allocTag),
    .pcie_tag_alloc_len (allocLen),
    .pcie_tag_full_n    (tagFullN),
    .rear_full_addr     (rearFullAddr),
    .fifo_front_addr    (fifoFrontAddr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", name, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Reference split: at most 2 units per read, never past a 4KB page edge.
  task automatic pushExpected(input logic [29:0] addr, input int len);
    logic [29:0] a;
    int          r;
    int          c;
    int          room;
    mrd_t        e;
    a = addr;
    r = len;
    while (r > 0) begin
      c = 2;
      if (r < c) c = r;
      room = 64 - int'(a[5:0]);
      if (room < c) c = room;
      e.addr = {a, 4'b0000};
      e.len  = 10'(c * 16);
      e.tag  = {5'b00001, expTag};
      expQ.push_back(e);
      expTag = expTag + 3'd1;
      a = a + 30'(c);
      r = r - c;
    end
  endtask

  task automatic applyStimulus(input logic [29:0] addr, input logic [6:0] len);
    checkOutput("ready_before_req", prpRdReqReady, 1);
    prpRdReq  = 1'b1;
    prpRdAddr = addr;
    prpRdLen  = len;
    tick();
    prpRdReq  = 1'b0;
  endtask

  task automatic waitReq(output bit seen);
    seen = 1'b0;
    for (int i = 0; i < 30; i++) begin
      if (txMrdReq === 1'b1) begin
        seen = 1'b1;
        return;
      end
      tick();
    end
    checkOutput("req_timeout", txMrdReq, 1);
  endtask

  task automatic serviceChunk(input int ackDelay);
    bit   seen;
    mrd_t e;
    e = expQ.pop_front();
    waitReq(seen);
    if (!seen) return;
    checkOutput("mrd_addr", txMrdAddr, e.addr);
    checkOutput("mrd_len", txMrdLen, e.len);
    checkOutput("mrd_tag", txMrdTag, e.tag);
    for (int d = 0; d < ackDelay; d++) begin
      tick();
      checkOutput("hold_req", txMrdReq, 1);
      checkOutput("hold_addr", txMrdAddr, e.addr);
      checkOutput("hold_len", txMrdLen, e.len);
      checkOutput("hold_tag", txMrdTag, e.tag);
      checkOutput("no_alloc_wo_ack", tagAlloc, 0);
    end
    txMrdReqAck = 1'b1;
    #1;
    checkOutput("alloc_pulse", tagAlloc, 1);
    checkOutput("alloc_tag", allocTag, e.tag);
    checkOutput("alloc_len", allocLen, e.len[5:4]);
    tick();
    txMrdReqAck = 1'b0;
    checkOutput("req_drop", txMrdReq, 0);
    checkOutput("alloc_once", tagAlloc, 0);
  endtask

  task automatic serviceAll(input int ackDelay);
    while (expQ.size() > 0) serviceChunk(ackDelay);
    tick();
    checkOutput("done_pulse", prpRdDone, 1);
    checkOutput("ready_after_done", prpRdReqReady, 1);
    tick();
    checkOutput("done_single", prpRdDone, 0);
  endtask

  initial begin
    rst           = 1'b1;
    prpRdReq      = 1'b0;
    prpRdAddr     = '0;
    prpRdLen      = '0;
    txMrdReqAck   = 1'b0;
    tagFullN      = 1'b1;
    rearFullAddr  = '0;
    fifoFrontAddr = '0;
    expTag        = '0;
    @(negedge clk);
    tick();

    checkOutput("rst_ready", prpRdReqReady, 1);
    checkOutput("rst_done", prpRdDone, 0);
    checkOutput("rst_req", txMrdReq, 0);
    checkOutput("rst_alloc", tagAlloc, 0);
    checkOutput("rst_addr", txMrdAddr, 0);
    checkOutput("rst_len", txMrdLen, 0);
    checkOutput("rst_tag", txMrdTag, 8'h08);
    checkOutput("rst_alloc_tag", allocTag, 8'h08);
    checkOutput("rst_alloc_len", allocLen, 0);
    rst = 1'b0;
    tick();

    $display("[TB] basic two-chunk fetch");
    expQ.push_back('{addr: 34'h1000, len: 10'd32, tag: 8'h08});
    expQ.push_back('{addr: 34'h1020, len: 10'd32, tag: 8'h09});
    expTag = 3'd2;
    applyStimulus(30'h100, 7'd4);
    serviceAll(0);

    $display("[TB] 4KB boundary split");
    expQ.push_back('{addr: 34'h3F0, len: 10'd16, tag: 8'h0A});
    expQ.push_back('{addr: 34'h400, len: 10'd32, tag: 8'h0B});
    expTag = 3'd4;
    applyStimulus(30'h3F, 7'd3);
    serviceAll(0);

    $display("[TB] zero-length fetch");
    applyStimulus(30'h55, 7'd0);
    checkOutput("zero_done", prpRdDone, 1);
    checkOutput("zero_no_req", txMrdReq, 0);
    tick();
    checkOutput("zero_done_single", prpRdDone, 0);
    checkOutput("zero_no_alloc", tagAlloc, 0);
    checkOutput("zero_ready", prpRdReqReady, 1);

    $display("[TB] spurious ack");
    txMrdReqAck = 1'b1;
    #1;
    checkOutput("spurious_alloc", tagAlloc, 0);
    tick();
    txMrdReqAck = 1'b0;
    checkOutput("spurious_req", txMrdReq, 0);
    checkOutput("spurious_ready", prpRdReqReady, 1);

    $display("[TB] FIFO space stall with wrapped pointers");
    rearFullAddr  = 6'b100000;
    fifoFrontAddr = 6'b000001;
    pushExpected(30'h200, 2);
    applyStimulus(30'h200, 7'd2);
    for (int i = 0; i < 6; i++) begin
      checkOutput("space_stall", txMrdReq, 0);
      tick();
    end
    fifoFrontAddr = 6'b000010;
    tick();
    checkOutput("space_release", txMrdReq, 1);
    serviceAll(0);
    rearFullAddr  = '0;
    fifoFrontAddr = '0;

    $display("[TB] tag full stall and delayed ack");
    tagFullN = 1'b0;
    pushExpected(30'h300, 2);
    applyStimulus(30'h300, 7'd2);
    for (int i = 0; i < 10; i++) begin
      checkOutput("tag_stall", txMrdReq, 0);
      tick();
    end
    tagFullN = 1'b1;
    tick();
    checkOutput("tag_release", txMrdReq, 1);
    serviceAll(5);

    $display("[TB] tag wrap over nine chunks");
    rst = 1'b1;
    tick();
    rst = 1'b0;
    expQ.delete();
    expTag = '0;
    tick();
    pushExpected(30'h1000, 18);
    applyStimulus(30'h1000, 7'd18);
    serviceAll(0);

    $display("[TB] reset during request");
    begin
      bit seen;
      pushExpected(30'h500, 4);
      applyStimulus(30'h500, 7'd4);
      waitReq(seen);
      rst = 1'b1;
      #1;
      checkOutput("midrst_req", txMrdReq, 0);
      checkOutput("midrst_ready", prpRdReqReady, 1);
      checkOutput("midrst_tag", txMrdTag, 8'h08);
      checkOutput("midrst_alloc", tagAlloc, 0);
      expQ.delete();
      expTag = '0;
      tick();
      rst = 1'b0;
      tick();
    end
    pushExpected(30'h600, 2);
    applyStimulus(30'h600, 7'd2);
    serviceAll(0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
